// File: rtl/crossy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crossy_pkg
//  Description : Shared types and constants for the lane spawner. Holds the
//                sequencer state enum, the LFSR seed and tap mask, the field
//                widths, and the helper that turns one LFSR word into a
//                lane's field set.
//  Revision    : 1.0  initial release
// ============================================================================
package crossy_pkg;

    // Sequencer states, in the order a spawn round visits them
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GEN    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_PULSE  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    // Galois LFSR for x^16 + x^14 + x^13 + x^11 (right-shifting form)
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Highest number of extra cars a lane may carry beyond its first car
    localparam logic [2:0]  MAX_EXTRA_CARS = 3'd4;

    // Per-lane field widths
    localparam int CAR_TYPE_W  = 2;
    localparam int CAR_COUNT_W = 3;
    localparam int CAR_SPEED_W = 3;

    // One lane's worth of generated fields
    typedef struct packed {
        logic                   dir;
        logic [CAR_TYPE_W-1:0]  ctype;
        logic [CAR_COUNT_W-1:0] count;
        logic [CAR_SPEED_W-1:0] speed;
    } lane_fields_t;

    // Derive a lane's fields from the low nine LFSR bits and the difficulty.
    // Count and speed are clamped in 4 bits so Level+1 = 8 cannot wrap.
    function automatic lane_fields_t gen_lane(input logic [8:0] r,
                                              input logic [2:0] level);
        lane_fields_t f;
        logic [3:0]   raw;
        logic [3:0]   cnt_cap;
        logic [3:0]   spd;
        logic [3:0]   spd_cap;

        f.dir   = r[6];
        f.ctype = r[8:7];

        // Fold the 0..7 draw into 0..4 extra cars
        raw = {1'b0, r[2:0]};
        if (raw > {1'b0, MAX_EXTRA_CARS}) begin
            raw = raw - {1'b0, MAX_EXTRA_CARS};
        end
        cnt_cap = 4'd1 + {2'b00, level[2:1]};
        f.count = (raw < cnt_cap) ? raw[2:0] : cnt_cap[2:0];

        // Speed is never 0 and is capped by difficulty (at most 7)
        spd = (r[5:3] == 3'd0) ? 4'd1 : {1'b0, r[5:3]};
        spd_cap = {1'b0, level} + 4'd1;
        if (spd_cap > 4'd7) begin
            spd_cap = 4'd7;
        end
        f.speed = (spd < spd_cap) ? spd[2:0] : spd_cap[2:0];

        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_spawner_if.sv
`default_nettype none
// ============================================================================
//  Module      : lane_spawner_if
//  Description : Request / lane-field bundle between a round controller
//                (master) and the lane spawner (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface lane_spawner_if #(
    parameter int NUM_LANES = 8
);
    import crossy_pkg::*;

    logic                               NewRound;
    logic [2:0]                         Level;
    logic [NUM_LANES-1:0]               LaneMask;
    logic [NUM_LANES-1:0]               SpawnEnable;
    logic [NUM_LANES-1:0]               Direction;
    logic [CAR_TYPE_W*NUM_LANES-1:0]    CarType;
    logic [CAR_COUNT_W*NUM_LANES-1:0]   CarCount;
    logic [CAR_SPEED_W*NUM_LANES-1:0]   CarSpeed;
    logic                               Busy;
    logic                               Done;

    // Round controller side
    modport master (
        output NewRound, Level, LaneMask,
        input  SpawnEnable, Direction, CarType, CarCount, CarSpeed, Busy, Done
    );

    // Spawner side
    modport slave (
        input  NewRound, Level, LaneMask,
        output SpawnEnable, Direction, CarType, CarCount, CarSpeed, Busy, Done
    );

endinterface
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr16
//  Description : Free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11.
//                Steps every cycle; recovers from the lock-up state by
//                reloading the seed.
//  Revision    : 1.0  initial release
// ============================================================================
module lfsr16
    import crossy_pkg::*;
(
    input  wire         Clk,
    input  wire         Reset,
    output logic [15:0] Q
);

    logic [15:0] r_q;

    // Seed on reset or on the all-zero lock-up state, otherwise shift with taps
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_q <= LFSR_SEED;
        end else if (r_q == 16'h0000) begin
            r_q <= LFSR_SEED;
        end else if (r_q[0]) begin
            r_q <= {1'b0, r_q[15:1]} ^ LFSR_TAPS;
        end else begin
            r_q <= {1'b0, r_q[15:1]};
        end
    end

    assign Q = r_q;

endmodule
`default_nettype wire

// File: rtl/lane_spawner.sv
`default_nettype none
// ============================================================================
//  Module      : lane_spawner
//  Description : On a NewRound request, generates Direction/CarType/
//                CarCount/CarSpeed for every lane from an LFSR (one lane per
//                cycle), waits one settle cycle, then raises SpawnEnable on
//                the unmasked lanes for PULSE_LEN cycles and signals Done.
//                All outputs are registered.
//  Revision    : 1.0  initial release
// ============================================================================
module lane_spawner
    import crossy_pkg::*;
#(
    parameter int NUM_LANES = 8,   // 1..16, must match the interface
    parameter int PULSE_LEN = 2    // >= 1
) (
    input  wire           Clk,
    input  wire           Reset,
    lane_spawner_if.slave bus
);

    localparam int IDX_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int PCNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_LANES - 1);
    localparam logic [PCNT_W-1:0] PULSE_LAST = PCNT_W'(PULSE_LEN - 1);

    state_t                             r_state;
    logic [IDX_W-1:0]                   r_idx;
    logic [PCNT_W-1:0]                  r_pcnt;
    logic [2:0]                         r_level;
    logic [NUM_LANES-1:0]               r_mask;

    logic [NUM_LANES-1:0]               r_spawn;
    logic [NUM_LANES-1:0]               r_dir;
    logic [CAR_TYPE_W*NUM_LANES-1:0]    r_type;
    logic [CAR_COUNT_W*NUM_LANES-1:0]   r_count;
    logic [CAR_SPEED_W*NUM_LANES-1:0]   r_speed;
    logic                               r_busy;
    logic                               r_done;

    logic [15:0]                        w_lfsr;
    lane_fields_t                       w_lane;
    logic                               w_unused_lfsr;

    lfsr16 u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .Q     (w_lfsr)
    );

    // Only the low nine bits feed the lane fields
    assign w_lane        = gen_lane(w_lfsr[8:0], r_level);
    assign w_unused_lfsr = ^w_lfsr[15:9];

    // Round sequencer: IDLE -> GEN (one lane per cycle) -> SETTLE -> PULSE -> FINISH
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_pcnt  <= '0;
            r_level <= 3'd0;
            r_mask  <= '0;
            r_spawn <= '0;
            r_dir   <= '0;
            r_type  <= '0;
            r_count <= '0;
            r_speed <= {NUM_LANES{3'd1}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.NewRound) begin
                        r_level <= bus.Level;
                        r_mask  <= bus.LaneMask;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_GEN;
                    end
                end

                ST_GEN: begin
                    for (int i = 0; i < NUM_LANES; i++) begin
                        if (int'(r_idx) == i) begin
                            r_dir[i] <= w_lane.dir;
                            r_type[i*CAR_TYPE_W +: CAR_TYPE_W]    <= w_lane.ctype;
                            r_count[i*CAR_COUNT_W +: CAR_COUNT_W] <= w_lane.count;
                            r_speed[i*CAR_SPEED_W +: CAR_SPEED_W] <= w_lane.speed;
                        end
                    end
                    // Index parks on the last lane rather than wrapping
                    if (r_idx == LAST_IDX) begin
                        r_state <= ST_SETTLE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end

                ST_SETTLE: begin
                    // Fields are already stable; raise strobes for the pulse window
                    r_spawn <= r_mask;
                    r_pcnt  <= '0;
                    r_state <= ST_PULSE;
                end

                ST_PULSE: begin
                    if (r_pcnt == PULSE_LAST) begin
                        r_spawn <= '0;
                        r_done  <= 1'b1;
                        r_state <= ST_FINISH;
                    end else begin
                        r_pcnt <= r_pcnt + PCNT_W'(1);
                    end
                end

                ST_FINISH: begin
                    // A request seen here is dropped on purpose
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_spawn <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.SpawnEnable = r_spawn;
    assign bus.Direction   = r_dir;
    assign bus.CarType     = r_type;
    assign bus.CarCount    = r_count;
    assign bus.CarSpeed    = r_speed;
    assign bus.Busy        = r_busy;
    assign bus.Done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_lane_spawner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lane_spawner
//  Description : Self-checking bench for lane_spawner with a behavioural
//                round/field model and a free-running LFSR reference.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lane_spawner;

    localparam int N = 8;
    localparam int P = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    lane_spawner_if #(.NUM_LANES(N)) bus ();

    lane_spawner #(.NUM_LANES(N), .PULSE_LEN(P)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: polynomial x^16+x^14+x^13+x^11, seeded on reset
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        if (s == 16'h0000) return SEED;
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    logic [15:0] m_lfsr;
    always @(posedge clk) m_lfsr <= rst ? SEED : lfsr_next(m_lfsr);

    // Expected lane fields after generation
    logic [N-1:0]   e_dir;
    logic [2*N-1:0] e_type;
    logic [3*N-1:0] e_cnt;
    logic [3*N-1:0] e_spd;

    task automatic predict(input logic [15:0] r0, input int lvl);
        logic [15:0] r;
        int raw, cap, cnt, s, lim;
        r = r0;
        for (int i = 0; i < N; i++) begin
            raw = int'(r[2:0]);
            if (raw > 4) raw = raw - 4;
            cap = 1 + lvl / 2;
            cnt = (raw < cap) ? raw : cap;
            s   = int'(r[5:3]);
            if (s < 1) s = 1;
            lim = (lvl + 1 > 7) ? 7 : lvl + 1;
            if (s > lim) s = lim;
            e_dir[i]        = r[6];
            e_type[2*i +: 2] = r[8:7];
            e_cnt[3*i +: 3]  = 3'(cnt);
            e_spd[3*i +: 3]  = 3'(s);
            r = lfsr_next(r);
        end
    endtask

    // One full round from IDLE; extra NewRound pulses at cycles xa/xb
    task automatic run_round(input int lvl, input logic [N-1:0] mask,
                             input int xa, input int xb);
        int dones;
        logic [N-1:0] exp_sp;
        bus.Level    = 3'(lvl);
        bus.LaneMask = mask;
        bus.NewRound = 1'b1;
        dones = 0;
        for (int k = 1; k <= N + P + 3; k++) begin
            @(negedge clk);
            if (k == 1) predict(m_lfsr, lvl);
            bus.NewRound = (k == xa) || (k == xb);
            bus.Level    = 3'($urandom);
            bus.LaneMask = N'($urandom);
            exp_sp = (k >= N + 2 && k <= N + 1 + P) ? mask : '0;
            if (bus.Done) dones++;
            checks++;
            if (bus.Busy !== (k <= N + 2 + P)) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b want=%b", k, bus.Busy, (k <= N + 2 + P));
            end
            checks++;
            if (bus.Done !== (k == N + 2 + P)) begin
                errors++;
                $display("FAIL done cyc=%0d got=%b want=%b", k, bus.Done, (k == N + 2 + P));
            end
            checks++;
            if (bus.SpawnEnable !== exp_sp) begin
                errors++;
                $display("FAIL spawn cyc=%0d got=%h want=%h", k, bus.SpawnEnable, exp_sp);
            end
            if (k >= N + 1) begin
                checks++;
                if (bus.Direction !== e_dir || bus.CarType !== e_type ||
                    bus.CarCount !== e_cnt || bus.CarSpeed !== e_spd) begin
                    errors++;
                    $display("FAIL fields cyc=%0d got=%h/%h/%h/%h want=%h/%h/%h/%h", k,
                             bus.Direction, bus.CarType, bus.CarCount, bus.CarSpeed,
                             e_dir, e_type, e_cnt, e_spd);
                end
            end
        end
        bus.NewRound = 1'b0;
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL done_count got=%0d want=1", dones);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (bus.SpawnEnable !== '0 || bus.Direction !== '0 || bus.CarType !== '0 ||
            bus.CarCount !== '0 || bus.CarSpeed !== {N{3'd1}} ||
            bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
            errors++;
            $display("FAIL %s outputs got sp=%h dir=%h ty=%h cnt=%h spd=%h b=%b d=%b want 0s with speed=%h",
                     tag, bus.SpawnEnable, bus.Direction, bus.CarType, bus.CarCount,
                     bus.CarSpeed, bus.Busy, bus.Done, {N{3'd1}});
        end
        checks++;
        if (dut.w_lfsr !== SEED) begin
            errors++;
            $display("FAIL %s lfsr got=%h want=%h", tag, dut.w_lfsr, SEED);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.NewRound = 1'b0;
        bus.Level = 3'd0;
        bus.LaneMask = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");
    endtask

    task automatic test_level0;
        run_round(0, 8'hFF, 0, 0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (bus.CarSpeed[3*i +: 3] !== 3'd1 || bus.CarCount[3*i +: 3] > 3'd1) begin
                errors++;
                $display("FAIL lvl0_lane%0d got spd=%0d cnt=%0d want spd=1 cnt<=1",
                         i, bus.CarSpeed[3*i +: 3], bus.CarCount[3*i +: 3]);
            end
        end
    endtask

    task automatic test_level7;
        run_round(7, 8'hA5, 0, 0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (bus.CarCount[3*i +: 3] > 3'd4 || bus.CarSpeed[3*i +: 3] == 3'd0) begin
                errors++;
                $display("FAIL lvl7_lane%0d got cnt=%0d spd=%0d want cnt<=4 spd 1..7",
                         i, bus.CarCount[3*i +: 3], bus.CarSpeed[3*i +: 3]);
            end
        end
    endtask

    task automatic test_ignore_newround;
        run_round(5, 8'h3C, 3, 11);
        run_round(2, 8'h81, N + 2 + P, 0);
    endtask

    task automatic test_random;
        for (int t = 0; t < 8; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_round(int'($urandom_range(0, 7)), N'($urandom), 0, 0);
        end
    endtask

    task automatic test_reset_mid;
        logic [N-1:0] mask;
        mask = 8'h5A;
        bus.Level = 3'd4;
        bus.LaneMask = mask;
        bus.NewRound = 1'b1;
        for (int k = 1; k <= N + 2; k++) begin
            @(negedge clk);
            bus.NewRound = 1'b0;
        end
        checks++;
        if (bus.SpawnEnable !== mask) begin
            errors++;
            $display("FAIL mid_pulse spawn got=%h want=%h", bus.SpawnEnable, mask);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("mid_reset");
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset cyc=%0d got done=%b busy=%b want 0/0", k, bus.Done, bus.Busy);
            end
        end
    endtask

    task automatic test_lfsr_run;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            checks++;
            if (dut.w_lfsr !== m_lfsr || dut.w_lfsr == 16'h0000) begin
                errors++;
                $display("FAIL lfsr step=%0d got=%h want=%h", k, dut.w_lfsr, m_lfsr);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.NewRound = 1'b0;
        bus.Level = 3'd0;
        bus.LaneMask = '0;
        @(negedge clk);
        test_reset();
        test_level0();
        test_level7();
        test_ignore_newround();
        test_random();
        test_reset_mid();
        test_lfsr_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
